// File: rtl/async_fifo_wr_ctrl_pkg.sv
// async_fifo_wr_ctrl_pkg: shared pointer width default and Gray conversions used by both FIFO clock domains
package async_fifo_wr_ctrl_pkg;
    localparam int DEFAULT_ADDR_WIDTH = 6;
    localparam int DEFAULT_ALMOST_FULL_LEVEL = 28;
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i + 1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/async_fifo_wr_ctrl_if.sv
// async_fifo_wr_ctrl_if: user write request, flags and dpram/read-domain pointer signals of the write side
interface async_fifo_wr_ctrl_if import async_fifo_wr_ctrl_pkg::*; #(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) ();
    logic                  i_wr_en;
    logic                  o_fifo_full;
    logic                  o_fifo_almost_full;
    logic                  o_overflow;
    logic [ADDR_WIDTH-1:0] ov_wr_level;
    logic [ADDR_WIDTH-2:0] ov_wr_addr_dpram;
    logic                  o_wr_en;
    logic [ADDR_WIDTH-1:0] ov_wr_addr_gray;
    logic [ADDR_WIDTH-1:0] iv_rd_addr_gray;
    modport master (
        input  i_wr_en, iv_rd_addr_gray,
        output o_fifo_full, o_fifo_almost_full, o_overflow, ov_wr_level,
               ov_wr_addr_dpram, o_wr_en, ov_wr_addr_gray
    );
    modport slave (
        output i_wr_en, iv_rd_addr_gray,
        input  o_fifo_full, o_fifo_almost_full, o_overflow, ov_wr_level,
               ov_wr_addr_dpram, o_wr_en, ov_wr_addr_gray
    );
endinterface

// File: rtl/async_fifo_wr_ctrl_gray_sync2.sv
// gray_sync2: two-flop synchronizer for a Gray pointer whose second stage holds the binary-converted value
module gray_sync2 import async_fifo_wr_ctrl_pkg::*; #(
    parameter int DATA_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] gray,
    output logic [DATA_WIDTH-1:0] bin
);
    logic [DATA_WIDTH-1:0] meta;
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            bin  <= '0;
        end else begin
            meta <= gray;
            bin  <= DATA_WIDTH'(gray2bin(32'(meta)));
        end
    end
endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// async_fifo_wr_ctrl: write-side pointer, Gray export and pessimistic full/level flags of an async FIFO
module async_fifo_wr_ctrl import async_fifo_wr_ctrl_pkg::*; #(
    parameter int ADDR_WIDTH        = DEFAULT_ADDR_WIDTH,
    parameter int ALMOST_FULL_LEVEL = DEFAULT_ALMOST_FULL_LEVEL
) (
    input logic                clk,
    input logic                reset,
    async_fifo_wr_ctrl_if.master bus
);
    logic [ADDR_WIDTH-1:0] wr_ptr, wr_nxt, rd_bin, lvl_nxt;
    logic                  wr_en;
    gray_sync2 #(.DATA_WIDTH(ADDR_WIDTH)) u_sync (
        .clk   (clk),
        .reset (reset),
        .gray  (bus.iv_rd_addr_gray),
        .bin   (rd_bin)
    );
    always_comb begin
        wr_en   = bus.i_wr_en & ~bus.o_fifo_full & ~reset;
        wr_nxt  = wr_ptr + ADDR_WIDTH'(wr_en);
        lvl_nxt = wr_nxt - rd_bin;
    end
    assign bus.o_wr_en          = wr_en;
    assign bus.ov_wr_addr_dpram = wr_ptr[ADDR_WIDTH-2:0];
    // Flags look at the next write pointer so the filling write blocks the very next request
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr                 <= '0;
            bus.ov_wr_addr_gray    <= '0;
            bus.ov_wr_level        <= '0;
            bus.o_fifo_full        <= 1'b0;
            bus.o_fifo_almost_full <= 1'b0;
            bus.o_overflow         <= 1'b0;
        end else begin
            wr_ptr                 <= wr_nxt;
            bus.ov_wr_addr_gray    <= ADDR_WIDTH'(bin2gray(32'(wr_nxt)));
            bus.ov_wr_level        <= lvl_nxt;
            bus.o_fifo_full        <= wr_nxt == {~rd_bin[ADDR_WIDTH-1], rd_bin[ADDR_WIDTH-2:0]};
            bus.o_fifo_almost_full <= lvl_nxt >= ADDR_WIDTH'(ALMOST_FULL_LEVEL);
            bus.o_overflow         <= bus.i_wr_en & bus.o_fifo_full;
        end
    end
endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// tb_async_fifo_wr_ctrl: directed and randomized checks of the write controller against an occupancy model
module tb_async_fifo_wr_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    async_fifo_wr_ctrl_if #(.ADDR_WIDTH(6)) bus ();
    async_fifo_wr_ctrl #(.ADDR_WIDTH(6), .ALMOST_FULL_LEVEL(28)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int rd = 0;
    int m_wr = 0, m_lvl = 0, rd_used = 0, h_old = 0, h_new = 0;
    bit m_full = 0, m_af = 0, m_ov = 0, started = 0, last_rst = 1;
    logic [5:0] prev_gray = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int occ();
        return (m_wr - rd + 64) % 64;
    endfunction

    // Reference model: pointers as integers, read pointer seen two edges late, flags from occupancy
    always @(posedge clk) begin
        last_rst = reset;
        if (reset) begin
            started = 1; m_wr = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ov = 0;
            h_old = 0; h_new = 0;
        end else begin
            m_ov = bus.i_wr_en && m_full;
            m_wr = (m_wr + int'(bus.i_wr_en && !m_full)) % 64;
            rd_used = h_old; h_old = h_new; h_new = rd;
            m_lvl = (m_wr - rd_used + 64) % 64;
            m_full = (m_lvl == 32);
            m_af = (m_lvl >= 28);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("wr_en", int'(bus.o_wr_en), int'(bus.i_wr_en && !m_full && !reset));
            chk("full", int'(bus.o_fifo_full), int'(m_full));
            chk("almost_full", int'(bus.o_fifo_almost_full), int'(m_af));
            chk("overflow", int'(bus.o_overflow), int'(m_ov));
            chk("level", int'(bus.ov_wr_level), m_lvl);
            chk("gray", int'(bus.ov_wr_addr_gray), m_wr ^ (m_wr >> 1));
            chk("dpram_addr", int'(bus.ov_wr_addr_dpram), m_wr % 32);
            if (!last_rst) chk("gray_step", int'($countones(bus.ov_wr_addr_gray ^ prev_gray) <= 1), 1);
            if (bus.o_wr_en) chk("no_overwrite", int'(occ() < 32), 1);
            prev_gray = bus.ov_wr_addr_gray;
        end
    end

    task automatic drive(input bit req, input bit adv, input bit rst);
        if (rst) rd = 0;
        else if (adv && occ() > 0) rd = (rd + 1) % 64;
        reset = rst;
        bus.i_wr_en = req;
        bus.iv_rd_addr_gray = 6'(rd ^ (rd >> 1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.i_wr_en = 1'b0;
        bus.iv_rd_addr_gray = '0;
        drive(0, 0, 1);
        drive(0, 0, 1);
        chk("rst_level", int'(bus.ov_wr_level), 0);
        chk("rst_full", int'(bus.o_fifo_full), 0);
        chk("rst_gray", int'(bus.ov_wr_addr_gray), 0);
        // Fill from empty: 32 accepted writes, the 33rd rejected
        for (int i = 0; i < 32; i++) drive(1, 0, 0);
        chk("fill_full", int'(bus.o_fifo_full), 1);
        chk("fill_level", int'(bus.ov_wr_level), 32);
        bus.i_wr_en = 1'b1;
        #1;
        chk("fill_wr_en33", int'(bus.o_wr_en), 0);
        @(posedge clk);
        #1;
        chk("fill_overflow", int'(bus.o_overflow), 1);
        chk("fill_gray", int'(bus.ov_wr_addr_gray), 'h30);
        chk("fill_level33", int'(bus.ov_wr_level), 32);
        drive(1, 0, 0);
        chk("overflow_cont", int'(bus.o_overflow), 1);
        // One read: full drops on the third edge only
        drive(0, 1, 0);
        drive(0, 0, 0);
        chk("sync_full_held", int'(bus.o_fifo_full), 1);
        drive(0, 0, 0);
        chk("sync_full_drop", int'(bus.o_fifo_full), 0);
        chk("sync_level31", int'(bus.ov_wr_level), 31);
        drive(1, 0, 0);
        chk("refill_level", int'(bus.ov_wr_level), 32);
        chk("refill_full", int'(bus.o_fifo_full), 1);
        // Almost-full threshold
        drive(0, 0, 1);
        for (int i = 0; i < 27; i++) drive(1, 0, 0);
        chk("af_27", int'(bus.o_fifo_almost_full), 0);
        drive(1, 0, 0);
        chk("af_28", int'(bus.o_fifo_almost_full), 1);
        chk("af_level", int'(bus.ov_wr_level), 28);
        chk("af_not_full", int'(bus.o_fifo_full), 0);
        // Reader trailing by four across the pointer wrap
        drive(0, 0, 1);
        for (int i = 0; i < 100; i++) begin
            drive(1, occ() >= 4, 0);
            chk("trail_not_full", int'(bus.o_fifo_full), 0);
        end
        chk("trail_gray", int'(bus.ov_wr_addr_gray), 'h36);
        chk("trail_dpram", int'(bus.ov_wr_addr_dpram), 4);
        // Reset while writing at level 20
        drive(0, 0, 1);
        for (int i = 0; i < 20; i++) drive(1, 0, 0);
        chk("mid_level20", int'(bus.ov_wr_level), 20);
        reset = 1'b1;
        bus.i_wr_en = 1'b1;
        #1;
        chk("mid_wr_en_rst", int'(bus.o_wr_en), 0);
        @(posedge clk);
        #1;
        chk("mid_level0", int'(bus.ov_wr_level), 0);
        chk("mid_gray0", int'(bus.ov_wr_addr_gray), 0);
        chk("mid_dpram0", int'(bus.ov_wr_addr_dpram), 0);
        chk("mid_ovf0", int'(bus.o_overflow), 0);
        chk("mid_full0", int'(bus.o_fifo_full), 0);
        drive(0, 0, 0);
        // Random traffic: slow reader first so the FIFO saturates, then faster
        for (int i = 0; i < 3000; i++)
            drive($urandom_range(0, 99) < 70, $urandom_range(0, 99) < (i < 1500 ? 40 : 75),
                  $urandom_range(0, 299) == 0);
        drive(0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/async_fifo_wr_ctrl.md
ASYNC_FIFO_WR_CTRL -- requirements
Module: async_fifo_wr_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 6, pointer width including wrap bit; FIFO depth SHALL be 2^(ADDR_WIDTH-1).
REQ-002 Parameter ALMOST_FULL_LEVEL, default 28, fill level at or above which o_fifo_almost_full asserts; legal range 1..2^(ADDR_WIDTH-1).
REQ-003 clk  input  1  write-domain clock; single clock for all logic in the block.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 i_wr_en  input  1  FIFO write request from the user.
REQ-006 o_fifo_full  output  1  FIFO full flag, registered.
REQ-007 o_fifo_almost_full  output  1  fill level >= ALMOST_FULL_LEVEL, registered.
REQ-008 o_overflow  output  1  one-cycle pulse, write request rejected while full, registered.
REQ-009 ov_wr_level  output  ADDR_WIDTH  write-side fill level, registered.
REQ-010 ov_wr_addr_dpram  output  ADDR_WIDTH-1  dpram write address = low ADDR_WIDTH-1 bits of binary write pointer.
REQ-011 o_wr_en  output  1  dpram write enable.
REQ-012 ov_wr_addr_gray  output  ADDR_WIDTH  Gray-coded write pointer, registered, to read domain.
REQ-013 iv_rd_addr_gray  input  ADDR_WIDTH  Gray-coded read pointer, read clock domain (asynchronous).

Function
REQ-014 o_wr_en SHALL equal i_wr_en AND NOT o_fifo_full, combinationally; the dpram write uses ov_wr_addr_dpram in the same cycle.
REQ-015 Binary write pointer SHALL increment by 1 on each rising edge where o_wr_en=1, wrapping 2^ADDR_WIDTH-1 -> 0; otherwise hold.
REQ-016 ov_wr_addr_gray SHALL be registered from bin-to-Gray of the next pointer value, so it always equals Gray(current pointer) with no extra cycle of lag and changes at most one bit per clk.
REQ-017 iv_rd_addr_gray SHALL pass through a 2-flop synchronizer; the second stage is Gray-to-binary converted and registered as the synchronized read pointer.
REQ-018 Full SHALL be registered as (next write pointer == synchronized read pointer next value with MSB inverted, other bits equal).
REQ-019 ov_wr_level SHALL be registered as (next write pointer - next synchronized read pointer) modulo 2^ADDR_WIDTH; range 0..2^(ADDR_WIDTH-1).
REQ-020 o_fifo_almost_full SHALL be registered as (next level >= ALMOST_FULL_LEVEL).
REQ-021 A change on iv_rd_addr_gray SHALL be reflected in full/level/almost_full on the 3rd rising clk edge after it is stable.
REQ-022 Full is pessimistic: deassertion is delayed by synchronizer latency, assertion is never late; a write SHALL never overwrite unread data.
REQ-023 i_wr_en=1 while o_fifo_full=1 SHALL leave pointer unchanged and set o_overflow for exactly the next cycle; continuous requests give continuous pulses.
REQ-024 Write and read-pointer advance in the same cycle SHALL both take effect; level unchanged, full not asserted.
REQ-025 Full flag SHALL assert on the edge of the write that fills the last entry, so a back-to-back following request is blocked.

Reset
REQ-026 On reset=1 at a rising edge: write pointer, ov_wr_addr_gray, synchronizer stages, synchronized read pointer, ov_wr_level, o_fifo_full, o_fifo_almost_full, o_overflow SHALL all become 0; ov_wr_addr_dpram=0.
REQ-027 During reset o_wr_en SHALL be 0 regardless of i_wr_en.
REQ-028 Reset mid-operation SHALL discard in-flight state; the read side is reset by the same system event and its pointer Gray 0 resynchronizes normally.

Structure
REQ-029 Shared package holds bin-to-Gray and Gray-to-bin functions and default ADDR_WIDTH; read-side logic uses the same package.
REQ-030 One sub-module gray_sync2 (2-flop Gray synchronizer plus registered Gray-to-binary, parameter DATA_WIDTH, synchronous reset) SHALL be instantiated; all other logic stays in async_fifo_wr_ctrl.

Verification (ADDR_WIDTH=6, ALMOST_FULL_LEVEL=28)
REQ-031 Reset, iv_rd_addr_gray=0, 33 consecutive i_wr_en -> o_wr_en high 32 cycles, o_fifo_full=1 after 32nd edge, 33rd: o_wr_en=0, o_overflow pulse, ov_wr_addr_gray=0x30, level=32.
REQ-032 28 writes from empty -> o_fifo_almost_full=1 after 28th edge, level=28, o_fifo_full=0.
REQ-033 Full, then iv_rd_addr_gray 0x00 -> 0x01 -> full deasserts and level=31 on 3rd edge; next write accepted.
REQ-034 100 writes with read pointer tracking 4 behind -> pointer wraps 63->0 (Gray 0x20->0x00), dpram addr 31->0, never full, every Gray step one bit.
REQ-035 Reset asserted at level=20 while writing -> all outputs 0 after that edge, o_wr_en=0 during reset.
